// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and data requesters onto one fixed-latency unified memory.
// Each access runs IDLE -> BUSY (MEM_LATENCY cycles) -> RESP (ready pulse).
module unified_mem_arbiter #(
    parameter int MEM_LATENCY  = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner_d
);

    localparam int SW = (STARVE_LIMIT < 4) ? 2 : $clog2(STARVE_LIMIT + 1);
    localparam logic [3:0]    CNT_INIT   = 4'(MEM_LATENCY - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          own_q, own_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          if_ready_q, if_ready_d;
    logic          d_ready_q, d_ready_d;
    logic          mem_req_q, mem_req_d;
    logic          busy_q, busy_d;
    logic          grant_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        own_d      = own_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        mem_req_d  = mem_req_q;
        busy_d     = busy_q;
        grant_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    // Fetch is forced once data has won STARVE_LIMIT times in a row
                    grant_d   = d_req && !(if_req && starve_q == STARVE_MAX);
                    state_d   = BUSY;
                    own_d     = grant_d;
                    cnt_d     = CNT_INIT;
                    addr_d    = grant_d ? d_addr : if_addr;
                    we_d      = grant_d && d_we;
                    wdata_d   = grant_d ? d_wdata : 32'h0;
                    mem_req_d = 1'b1;
                    busy_d    = 1'b1;
                    if (grant_d && if_req) begin
                        if (starve_q != STARVE_MAX) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else begin
                        starve_d = '0;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    if_ready_d = !own_q;
                    d_ready_d  = own_q;
                    if (own_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            starve_q   <= '0;
            own_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            own_q      <= own_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
            mem_req_q  <= mem_req_d;
            busy_q     <= busy_d;
        end
    end

    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign owner_d   = own_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: latency-4 instance plus a
// latency-1 instance, each with a fixed-latency memory model.
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // latency-4 instance
    logic        if_req, if_ready, d_req, d_we, d_ready;
    logic        mem_req, mem_we, busy, owner_d;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // latency-1 instance
    logic        if_req1, if_ready1, d_req1, d_we1, d_ready1;
    logic        mem_req1, mem_we1, busy1, owner_d1;
    logic [31:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

    unified_mem_arbiter #(.MEM_LATENCY(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner_d(owner_d)
    );

    unified_mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(3)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1),
        .if_ready(if_ready1), .if_rdata(if_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_ready(d_ready1), .d_rdata(d_rdata1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .busy(busy1), .owner_d(owner_d1)
    );

    // memory model: write commits on the 4th consecutive mem_req cycle
    logic [31:0] mem [0:255];
    logic        loaded = 1'b0;
    int          run = 0;

    assign mem_rdata  = mem[mem_addr[9:2]];
    assign mem_rdata1 = mem[mem_addr1[9:2]];

    always @(posedge clk) begin
        if (!loaded) begin
            loaded <= 1'b1;
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h00500093;
            mem[1]  <= 32'h00A00113;
            mem[2]  <= 32'h00000013;
            mem[32] <= 32'hCAFEF00D;
            mem[64] <= 32'h0000DEAD;
        end else if (reset || !mem_req) begin
            run <= 0;
        end else begin
            run <= run + 1;
            if (mem_we && run == 3) mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    typedef struct {
        bit          is_d;
        bit          chk;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sb4[$];
    exp_t sb1[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic push4(input bit is_d, input bit chk,
                         input logic [31:0] data, input int at);
        exp_t e;
        e.is_d = is_d; e.chk = chk; e.data = data; e.at = at;
        sb4.push_back(e);
    endtask

    task automatic wait_rdy4();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_ready || d_ready) return;
        end
        errs++;
        checks++;
        $display("FAIL ready_timeout: got no ready expected ready");
    endtask

    // monitors
    always @(negedge clk) begin
        if (if_ready || d_ready) begin
            check("both_ready", 32'(if_ready && d_ready), 32'd0);
            if (sb4.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb4.pop_front();
                check("owner", 32'(d_ready), 32'(e.is_d));
                check("ready_cycle", 32'(cyc), 32'(e.at));
                if (e.chk) check("rdata", d_ready ? d_rdata : if_rdata, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (if_ready1 || d_ready1) begin
            if (sb1.size() == 0) begin
                check("unexpected_ready1", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb1.pop_front();
                check("owner1", 32'(d_ready1), 32'(e.is_d));
                check("ready_cycle1", 32'(cyc), 32'(e.at));
                check("rdata1", if_rdata1, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        exp_t e1;
        reset = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        if_req1 = 0; if_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0;
        d_wdata1 = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'({if_ready, d_ready}), 32'd0);
        check("rst_mem", 32'({mem_req, mem_we, busy, owner_d}), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_rdata", if_rdata | d_rdata, 32'h0);

        // single fetch after reset release
        reset = 1'b0;
        if_req = 1; if_addr = 32'h0;
        push4(0, 1, 32'h00500093, cyc + 5);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("f_mem_req", 32'(mem_req), 32'd1);
            check("f_mem_addr", mem_addr, 32'h0);
        end
        wait_rdy4();
        if_req = 0;
        @(negedge clk);
        check("f_busy_after", 32'({busy, mem_req}), 32'd0);

        // simultaneous requests: data first, fetch after
        c = cyc;
        d_req = 1; d_we = 0; d_addr = 32'h100;
        if_req = 1; if_addr = 32'h4;
        push4(1, 1, 32'h0000DEAD, c + 5);
        push4(0, 1, 32'h00A00113, c + 11);
        @(negedge clk);
        check("both_owner", 32'(owner_d), 32'd1);
        wait_rdy4();
        d_req = 0;
        wait_rdy4();
        if_req = 0;
        check("d_rdata_hold", d_rdata, 32'h0000DEAD);
        @(negedge clk);

        // continuous data with fetch waiting: D,D,D,F,D
        c = cyc;
        d_req = 1; d_we = 0; d_addr = 32'h100;
        if_req = 1; if_addr = 32'h8;
        push4(1, 1, 32'h0000DEAD, c + 5);
        push4(1, 1, 32'h0000DEAD, c + 11);
        push4(1, 1, 32'h0000DEAD, c + 17);
        push4(0, 1, 32'h00000013, c + 23);
        push4(1, 1, 32'h0000DEAD, c + 29);
        for (int i = 0; i < 5; i++) begin
            wait_rdy4();
            if (i == 3) if_req = 0;
            if (i == 4) d_req = 0;
        end
        @(negedge clk);

        // store
        c = cyc;
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678;
        push4(1, 0, 32'h0, c + 5);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("st_mem_we", 32'({mem_req, mem_we}), 32'd3);
            check("st_mem_addr", mem_addr, 32'h40);
            check("st_mem_wdata", mem_wdata, 32'h12345678);
        end
        wait_rdy4();
        d_req = 0; d_we = 0;
        @(negedge clk);
        check("st_mem_word", mem[16], 32'h12345678);

        // reset in cycle 2 of a store aborts it
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h55555555;
        @(negedge clk);
        check("ab_mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        d_req = 0; d_we = 0;
        @(negedge clk);
        check("ab_ctrl", 32'({mem_req, mem_we, busy, owner_d}), 32'd0);
        check("ab_ready", 32'({if_ready, d_ready}), 32'd0);
        check("ab_addr", mem_addr | mem_wdata, 32'h0);
        check("ab_rdata", if_rdata | d_rdata, 32'h0);
        repeat (6) @(negedge clk);
        check("ab_mem_word", mem[32], 32'hCAFEF00D);
        reset = 1'b0;
        @(negedge clk);

        // latency-1 instance, fetch dropped during BUSY
        c = cyc;
        if_req1 = 1; if_addr1 = 32'h0;
        e1.is_d = 0; e1.chk = 1; e1.data = 32'h00500093; e1.at = c + 2;
        sb1.push_back(e1);
        @(negedge clk);
        check("l1_mem_req", 32'({mem_req1, if_ready1}), 32'd2);
        if_req1 = 0;
        @(negedge clk);
        check("l1_ready", 32'(if_ready1), 32'd1);
        check("l1_mem_req_off", 32'(mem_req1), 32'd0);
        @(negedge clk);
        check("l1_idle", 32'({busy1, if_ready1}), 32'd0);

        for (int i = 0; i < 20 && (sb4.size() + sb1.size()) != 0; i++) begin
            @(negedge clk);
        end
        check("sb_leftover", 32'(sb4.size() + sb1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch requester (IF) and data-access requester (MEM stage).
- Arbitrates between the two and sequences each multi-cycle access through an FSM.
- Returns per-requester ready pulses. The pipeline uses the absence of ready as its stall condition for PC and the pipeline registers.

Parameters:
- MEM_LATENCY, 4, cycles mem_req is held before mem_rdata is valid (legal range 1..15).
- STARVE_LIMIT, 3, consecutive data grants allowed while fetch waits before fetch is forced.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  32  fetch byte address
- if_ready  out  1  one-cycle pulse: fetch done, if_rdata valid this cycle
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_ready  out  1  one-cycle pulse: data access done, d_rdata valid for loads
- d_rdata  out  32  load data
- mem_req  out  1  memory access active
- mem_we  out  1  write enable, qualified by mem_req
- mem_addr  out  32  latched access address
- mem_wdata  out  32  latched store data
- mem_rdata  in  32  memory read data, valid on the last BUSY cycle
- busy  out  1  state != IDLE
- owner_d  out  1  current transaction owner (1 = data, 0 = fetch); meaningful when busy

Behaviour:
- Reset, at posedge with reset=1:
  - state = IDLE, cnt = 0, starve_cnt = 0.
  - All outputs drive 0: ready pulses, rdata, mem_*, busy, owner_d.
  - Reset mid-transaction aborts it: no ready pulse is issued, and mem_req drops on the next cycle.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If neither request is asserted, stay in IDLE.
  - Otherwise, at the posedge, pick a winner:
    - data wins if d_req && !(if_req && starve_cnt == STARVE_LIMIT);
    - else fetch wins.
  - Latch the winner's addr, we (forced to 0 for fetch) and wdata (0 for fetch). Set owner_d, set cnt = MEM_LATENCY-1, go to BUSY.
- starve_cnt update at each grant:
  - Data grant with if_req=1: increment, saturating at STARVE_LIMIT.
  - Fetch grant, or data grant with if_req=0: clear to 0.
- BUSY:
  - mem_req = 1; mem_we/mem_addr/mem_wdata come from the latches and are stable for all MEM_LATENCY cycles.
  - If cnt != 0: decrement cnt.
  - If cnt == 0: capture mem_rdata into the owner's rdata register, go to RESP.
  - The memory commits a write on the final BUSY cycle. An abort before that cycle leaves memory unchanged.
- RESP:
  - Pulse the owner's ready for exactly one cycle; mem_req = 0; next state is IDLE.
  - The other requester's ready stays 0.
- Latency: the grant edge is cycle 0. mem_req is high in cycles 1..MEM_LATENCY, and ready is high in cycle MEM_LATENCY+1. Peak throughput is one access per MEM_LATENCY+2 cycles.
- rdata registers:
  - if_rdata and d_rdata hold their last captured value until the next capture for the same owner.
  - A store leaves d_rdata as whatever mem_rdata was at capture; consumers ignore it.
- Request rules:
  - A requester keeps req and operands stable until its ready pulse. The arbiter samples them only at the grant edge.
  - Dropping req mid-transaction does not cancel it; ready still pulses.
  - In the cycle after ready, the requester must either drop req or present a new request. A req still high in IDLE is a new transaction.
- Simultaneous events:
  - Both requests asserted in IDLE: resolved by the priority rule above.
  - Requests arriving during BUSY/RESP wait in IDLE.
- Widths: cnt is 4 bits, starve_cnt is 2 bits minimum (sized for STARVE_LIMIT); no other arithmetic.

Test Plan:
- Reset released, if_req=1, if_addr=0x0, memory returns 0x00500093 → mem_req high cycles 1–4, if_ready pulse in cycle 5 with if_rdata=0x00500093, busy=0 in cycle 6.
- Both requests at cycle 0 (d_addr=0x100, load, mem returns 0xDEAD) → data granted first, d_ready in cycle 5 with d_rdata=0xDEAD; fetch granted at cycle 6, if_ready at cycle 11.
- d_req held continuously with if_req=1, STARVE_LIMIT=3 → grant order D,D,D,F,D…; starve_cnt is 3 at the fourth arbitration, then clears.
- Store d_we=1, d_addr=0x40, d_wdata=0x12345678 → mem_we=1 with stable addr/wdata for 4 cycles, d_ready pulse in cycle 5, if_ready stays 0, memory word 0x40 = 0x12345678.
- Reset asserted in cycle 2 of a store → mem_req=0 the next cycle, no ready pulse, memory word unchanged, all outputs 0, state IDLE.
- MEM_LATENCY=1, fetch only → mem_req for 1 cycle, if_ready in cycle 2; if_req dropped in cycle 1 still yields the if_ready pulse.
